// File: rtl/stage_if_prefetch_pkg.sv
// stage_if_prefetch_pkg: shared fetch-stage states, widths and cache slice helpers
package stage_if_prefetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] ZeroWord = '0;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} if_state_e;
  function automatic logic [ADDR_W-1:0] index_bits(input logic [ADDR_W-1:0] pc);
    return pc >> 2;
  endfunction
  function automatic logic [ADDR_W-1:0] tag_bits(input logic [ADDR_W-1:0] pc, input int index_w);
    return pc >> (index_w + 2);
  endfunction
endpackage

// File: rtl/stage_if_prefetch_queue.sv
// if_inst_queue: synchronous {pc, inst} FIFO toward ID with a flush that discards all entries
module if_inst_queue #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign rdata = mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else if (flush) begin
      rd <= wr;
    end else begin
      if (push && !full) wr <= wr + 1'b1;
      if (pop && !empty) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full && !flush) mem[wr[AW-1:0]] <= wdata;
endmodule

// File: rtl/stage_if_prefetch.sv
// stage_if_prefetch: I-cache lookup, multi-beat refill and instruction queue toward ID.
// Define IF_PERF_CNT_EN to add hit/miss performance counter ports.
module stage_if_prefetch
  import stage_if_prefetch_pkg::*;
#(
  parameter int MEM_BYTES = 1,
  parameter int QDEPTH = 4,
  parameter int INDEX_W = 7,
  parameter int TAG_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   branch_en_i,
  input  logic [ADDR_W-1:0]      branch_addr_i,
  input  logic                   id_ready_i,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]            hit_cnt_o,
  output logic [31:0]            miss_cnt_o,
`endif
  output logic                   inst_valid_o,
  output logic [ADDR_W-1:0]      pc_o,
  output logic [INST_W-1:0]      inst_o,
  output logic                   mem_req_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic                   mem_stall_i,
  input  logic [8*MEM_BYTES-1:0] mem_data_i,
  output logic [INDEX_W-1:0]     cache_index_o,
  output logic [TAG_W-1:0]       cache_tag_o,
  input  logic                   cache_hit_i,
  input  logic [INST_W-1:0]      cache_data_i,
  output logic                   cache_we_o,
  output logic [INDEX_W-1:0]     cache_windex_o,
  output logic [TAG_W-1:0]       cache_wtag_o,
  output logic [INST_W-1:0]      cache_wdata_o
);
  localparam int BEATS = 4 / MEM_BYTES;
  localparam int BW = $clog2(BEATS + 1);
  localparam int KW = BEATS > 1 ? $clog2(BEATS) : 1;
  if_state_e state, state_n;
  logic [ADDR_W-1:0] fetch_pc, pc_n, lookup_pc;
  logic [BW-1:0] beat, beat_n;
  logic [KW-1:0] pend_k, pend_k_n;
  logic pend, pend_n, push, full, empty, lookup_go;
  logic [INST_W-1:0] word, word_n;
  logic [ADDR_W+INST_W-1:0] qdata, head;
  assign lookup_go = state == IDLE && !branch_en_i && !full;
  assign lookup_pc = branch_en_i ? branch_addr_i : fetch_pc;
  assign cache_index_o = INDEX_W'(index_bits(lookup_pc));
  assign cache_tag_o = TAG_W'(tag_bits(lookup_pc, INDEX_W));
  assign cache_windex_o = cache_we_o ? INDEX_W'(index_bits(fetch_pc)) : '0;
  assign cache_wtag_o = cache_we_o ? TAG_W'(tag_bits(fetch_pc, INDEX_W)) : '0;
  assign cache_wdata_o = cache_we_o ? word : ZeroWord;
  assign mem_req_o = state == REFILL && beat < BW'(BEATS);
  assign mem_addr_o = mem_req_o ? fetch_pc + 32'(beat) * 32'(MEM_BYTES) : ZeroWord;
  assign inst_valid_o = !empty;
  assign {pc_o, inst_o} = empty ? head : qdata;
  always_comb begin
    state_n = state;
    pc_n = fetch_pc;
    beat_n = beat;
    pend_n = 1'b0;
    pend_k_n = pend_k;
    word_n = word;
    push = 1'b0;
    cache_we_o = 1'b0;
    if (branch_en_i) begin
      state_n = IDLE;
      pc_n = branch_addr_i;
      beat_n = '0;
    end else if (state == IDLE) begin
      if (lookup_go && cache_hit_i) begin
        push = 1'b1;
        pc_n = fetch_pc + 32'd4;
      end else if (lookup_go) begin
        state_n = REFILL;
        beat_n = '0;
      end
    end else if (state == REFILL) begin
      if (mem_req_o && !mem_stall_i) begin
        beat_n = beat + 1'b1;
        pend_n = 1'b1;
        pend_k_n = KW'(beat);
      end
      // Data lags its beat by one cycle; the last beat's data completes the word.
      if (pend) begin
        word_n[int'(pend_k) * 8 * MEM_BYTES +: 8 * MEM_BYTES] = mem_data_i;
        state_n = pend_k == KW'(BEATS - 1) ? WRITE : REFILL;
      end
    end else begin
      push = 1'b1;
      cache_we_o = 1'b1;
      pc_n = fetch_pc + 32'd4;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      beat <= '0;
      pend <= 1'b0;
      pend_k <= '0;
      word <= ZeroWord;
      head <= '0;
    end else begin
      state <= state_n;
      fetch_pc <= pc_n;
      beat <= beat_n;
      pend <= pend_n;
      pend_k <= pend_k_n;
      word <= word_n;
      if (!empty) head <= qdata;
    end
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_cnt_o <= '0;
      miss_cnt_o <= '0;
    end else begin
      hit_cnt_o <= hit_cnt_o + 32'(lookup_go && cache_hit_i);
      miss_cnt_o <= miss_cnt_o + 32'(lookup_go && !cache_hit_i);
    end
`endif
  if_inst_queue #(.DEPTH(QDEPTH), .W(ADDR_W + INST_W)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (branch_en_i),
    .push  (push),
    .wdata ({fetch_pc, state == WRITE ? word : cache_data_i}),
    .pop   (id_ready_i),
    .rdata (qdata),
    .full  (full),
    .empty (empty)
  );
endmodule
